// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases reset domains one at a time in index order and supervises their acks
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   SW_RST_REQ,
  input  logic [NUM_DOMAINS-1:0] DOMAIN_ACK,
  output logic [NUM_DOMAINS-1:0] DOMAIN_RST,
  output logic                   SEQ_DONE,
  output logic                   SEQ_ERR,
  output logic [2:0]             ERR_DOMAIN
);
  localparam int HG   = HOLD_CYCLES > GAP_CYCLES ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CMAX = HG > ACK_TIMEOUT ? HG : ACK_TIMEOUT;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {HOLD, RELEASE, WAIT_ACK, GAP, DONE, ERROR} state_t;
  state_t state_q, state_d;
  logic [2:0] idx_q, idx_d, err_dom_q, err_dom_d, loss_idx, fault_idx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NUM_DOMAINS-1:0] domain_rst_q, domain_rst_d, cur, nxt, acked, loss;
  logic done_q, done_d, err_q, err_d, ack_cur, last, fault, restart;
  // next-state, counter and output computation; a lost ack outranks timeout and advance
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    domain_rst_d = domain_rst_q;
    done_d       = done_q;
    err_d        = err_q;
    err_dom_d    = err_dom_q;
    fault        = 1'b0;
    restart      = 1'b0;
    cur          = '0;
    nxt          = '0;
    acked        = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      cur[i]   = 3'(i) == idx_q;
      nxt[i]   = 3'(i) == idx_q + 3'd1;
      acked[i] = state_q == DONE || (state_q == GAP && 3'(i) <= idx_q) || (state_q == WAIT_ACK && 3'(i) < idx_q);
    end
    loss     = acked & ~DOMAIN_ACK;
    loss_idx = '0;
    for (int i = NUM_DOMAINS - 1; i >= 0; i--)
      if (loss[i]) loss_idx = 3'(i);
    fault_idx = |loss ? loss_idx : idx_q;
    ack_cur   = |(DOMAIN_ACK & cur);
    last      = idx_q == 3'(NUM_DOMAINS - 1);
    case (state_q)
      HOLD:
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d      = RELEASE;
          cnt_d        = '0;
          domain_rst_d = domain_rst_q & ~cur;
        end else cnt_d = cnt_q + CW'(1);
      RELEASE: begin
        state_d = WAIT_ACK;
        cnt_d   = CW'(1);
      end
      WAIT_ACK:
        if (|loss || (!ack_cur && cnt_q == CW'(ACK_TIMEOUT - 1))) fault = 1'b1;
        else if (ack_cur) begin
          state_d = last ? DONE : GAP;
          done_d  = last;
          cnt_d   = '0;
        end else cnt_d = cnt_q + CW'(1);
      GAP:
        if (|loss) fault = 1'b1;
        else if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d      = RELEASE;
          idx_d        = idx_q + 3'd1;
          cnt_d        = '0;
          domain_rst_d = domain_rst_q & ~nxt;
        end else cnt_d = cnt_q + CW'(1);
      DONE:
        if (|loss) fault = 1'b1;
        else restart = SW_RST_REQ;
      ERROR: restart = SW_RST_REQ;
      default: state_d = HOLD;
    endcase
    if (fault) begin
      state_d      = ERROR;
      domain_rst_d = '1;
      done_d       = 1'b0;
      err_d        = 1'b1;
      err_dom_d    = fault_idx;
    end
    if (restart) begin
      state_d      = HOLD;
      idx_d        = '0;
      cnt_d        = '0;
      domain_rst_d = '1;
      done_d       = 1'b0;
      err_d        = 1'b0;
    end
  end
  // state and registered outputs; reset forces every domain back into reset at once
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= HOLD;
      idx_q        <= '0;
      cnt_q        <= '0;
      domain_rst_q <= '1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_dom_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      domain_rst_q <= domain_rst_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_dom_q    <= err_dom_d;
    end
  end
  assign DOMAIN_RST = domain_rst_q;
  assign SEQ_DONE   = done_q;
  assign SEQ_ERR    = err_q;
  assign ERR_DOMAIN = err_dom_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// tb_rst_seq_ctrl: vector table plus scoreboard bench for the reset sequencer
module tb_rst_seq_ctrl;
  logic clk = 1'b0, rst = 1'b0, sw = 1'b0;
  logic [2:0] ack = '0, drst, edom;
  logic done, err;
  typedef struct { logic [2:0] ack; logic [2:0] rst; logic done; } vec_t;
  typedef struct { string name; logic [7:0] v; } exp_t;
  vec_t tbl [16];
  exp_t sb [$];
  exp_t cur;
  int n_run = 0, n_fail = 0;

  rst_seq_ctrl dut (
    .CLK(clk), .RST(rst), .SW_RST_REQ(sw), .DOMAIN_ACK(ack),
    .DOMAIN_RST(drst), .SEQ_DONE(done), .SEQ_ERR(err), .ERR_DOMAIN(edom)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {drst, done, err, edom};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_run++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got rst=%b done=%b err=%b edom=%0d, want rst=%b done=%b err=%b edom=%0d",
               name, got[7:5], got[4], got[3], got[2:0], want[7:5], want[4], want[3], want[2:0]);
    end
  endtask

  // scoreboard: each expectation pushed at a falling edge is checked just after the next rising edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      check(cur.name, obs(), cur.v);
    end
  end

  task automatic step(input string name, input logic [2:0] a, input logic s, input logic [7:0] want);
    ack = a;
    sw  = s;
    sb.push_back(exp_t'{name, want});
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [2:0] a);
    ack = a;
    sw  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_table(input string name, input bit all_high, input int sw_row, input logic [2:0] ed);
    for (int i = 0; i < 16; i++)
      step($sformatf("%s[%0d]", name, i), all_high ? 3'b111 : tbl[i].ack, i == sw_row,
           {tbl[i].rst, tbl[i].done, 1'b0, ed});
  endtask

  initial begin
    // row i is the (i+1)-th edge after sequencing starts: release at edges 4, 8, 12, done at 14
    for (int i = 0; i < 16; i++) begin
      tbl[i].ack  = i < 4 ? 3'b000 : i < 8 ? 3'b001 : i < 12 ? 3'b011 : 3'b111;
      tbl[i].rst  = i < 3 ? 3'b111 : i < 7 ? 3'b110 : i < 11 ? 3'b100 : 3'b000;
      tbl[i].done = i >= 13;
    end
    #1 rst = 1'b1;
    #1 check("reset", obs(), {3'b111, 1'b0, 1'b0, 3'd0});
    @(negedge clk);
    rst = 1'b0;
    run_table("nominal", 1'b0, -1, 3'd0);
    step("ack_loss", 3'b110, 1'b0, {3'b111, 1'b0, 1'b1, 3'd0});
    step("err_hold", 3'b111, 1'b0, {3'b111, 1'b0, 1'b1, 3'd0});
    step("sw_from_err", 3'b111, 1'b1, {3'b111, 1'b0, 1'b0, 3'd0});
    idle(22, 3'b101);
    step("pre_timeout", 3'b101, 1'b0, {3'b100, 1'b0, 1'b0, 3'd0});
    step("timeout", 3'b101, 1'b0, {3'b111, 1'b0, 1'b1, 3'd1});
    step("recover", 3'b111, 1'b1, {3'b111, 1'b0, 1'b0, 3'd1});
    run_table("recovered", 1'b1, -1, 3'd1);
    rst = 1'b1;
    #1 check("async_done", obs(), {3'b111, 1'b0, 1'b0, 3'd0});
    @(negedge clk);
    rst = 1'b0;
    run_table("early_ack", 1'b1, 9, 3'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(6, 3'b111);
    step("gap_pre", 3'b111, 1'b0, {3'b110, 1'b0, 1'b0, 3'd0});
    rst = 1'b1;
    #1 check("async_gap", obs(), {3'b111, 1'b0, 1'b0, 3'd0});
    @(negedge clk);
    rst = 1'b0;
    run_table("restart", 1'b1, -1, 3'd0);
    @(negedge clk);
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d pending, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter NUM_DOMAINS, default 3: number of sequenced reset domains (1..8).
REQ-002 Parameter HOLD_CYCLES, default 4: cycles all domains stay in reset after RST deasserts (>=1).
REQ-003 Parameter GAP_CYCLES, default 2: cycles between a domain's ack and the next domain's release (>=1).
REQ-004 Parameter ACK_TIMEOUT, default 16: maximum cycles allowed for a released domain to raise its ack (>=2).
REQ-005 CLK  input  1  single clock for all logic.
REQ-006 RST  input  1  reset, asynchronous assert, active-high; the clock and reset are fixed as one clock and an asynchronous active-high reset.
REQ-007 SW_RST_REQ  input  1  synchronous software re-sequence request, level sampled on CLK.
REQ-008 DOMAIN_ACK  input  NUM_DOMAINS  per-domain "out of reset and alive" indication, synchronous to CLK.
REQ-009 DOMAIN_RST  output  NUM_DOMAINS  per-domain reset, active-high, registered.
REQ-010 SEQ_DONE  output  1  all domains released and acked, registered.
REQ-011 SEQ_ERR  output  1  sequencing fault latched, registered.
REQ-012 ERR_DOMAIN  output  3  index of the faulting domain, valid while SEQ_ERR=1.

Function
REQ-013 The FSM SHALL have states HOLD, RELEASE, WAIT_ACK, GAP, DONE and ERROR, and only these.
REQ-014 HOLD: DOMAIN_RST all ones; a counter counts HOLD_CYCLES edges, then the FSM moves to RELEASE with domain index idx=0.
REQ-015 RELEASE (1 cycle): clear DOMAIN_RST[idx] on that edge, load the timeout counter, go to WAIT_ACK.
REQ-016 WAIT_ACK: on the first edge sampling DOMAIN_ACK[idx]=1, go to GAP if idx<NUM_DOMAINS-1, else go to DONE.
REQ-017 WAIT_ACK timeout: if ACK_TIMEOUT edges pass after the release edge without the ack, go to ERROR with ERR_DOMAIN=idx.
REQ-018 GAP: count GAP_CYCLES edges, increment idx, go to RELEASE.
REQ-019 Domains SHALL be released strictly in ascending index order, one at a time, and never re-released within one sequence.
REQ-020 Ack loss: in WAIT_ACK, GAP or DONE, if any already-acked domain's ack is sampled 0, go to ERROR with ERR_DOMAIN = the lowest such index; ack loss takes priority over a same-cycle timeout or advance.
REQ-021 ERROR: DOMAIN_RST all ones on the entry edge, SEQ_ERR=1, SEQ_DONE=0; stay until SW_RST_REQ=1 is sampled, then go to HOLD and clear SEQ_ERR.
REQ-022 DONE: SEQ_DONE=1; SW_RST_REQ=1 sampled -> DOMAIN_RST all ones, SEQ_DONE=0, go to HOLD.
REQ-023 SW_RST_REQ SHALL be ignored in HOLD, RELEASE, WAIT_ACK and GAP.
REQ-024 DOMAIN_ACK bits of domains not yet released SHALL be ignored.
REQ-025 Counters SHALL be sized to their parameter with no wrap-around; each reloads on state entry.
REQ-026 ERR_DOMAIN SHALL hold its value until the next entry to ERROR, and read 0 after reset.

Reset
REQ-027 RST=1 SHALL asynchronously force: state HOLD, DOMAIN_RST all ones, SEQ_DONE=0, SEQ_ERR=0, ERR_DOMAIN=0, idx=0, counters cleared.
REQ-028 RST asserted mid-sequence (any state) SHALL reassert every DOMAIN_RST bit immediately, without waiting for a clock edge.
REQ-029 After RST deasserts, sequencing SHALL restart from HOLD, with no memory of the prior progress.

Verification (defaults: NUM_DOMAINS=3, HOLD=4, GAP=2, TIMEOUT=16)
REQ-030 Nominal: RST pulse, each ack raised 1 cycle after its release -> DOMAIN_RST goes 111 -> 110 (edge 4) -> 100 -> 000 with 2-edge gaps after each ack; SEQ_DONE=1, SEQ_ERR=0.
REQ-031 Timeout: domain 1 ack never rises -> ERROR 16 edges after its release; DOMAIN_RST=111, SEQ_ERR=1, ERR_DOMAIN=1.
REQ-032 Ack loss: in DONE, drop DOMAIN_ACK[0] for 1 cycle -> DOMAIN_RST=111, SEQ_ERR=1, ERR_DOMAIN=0, SEQ_DONE=0.
REQ-033 Recovery: from ERROR, SW_RST_REQ=1 for 1 cycle -> SEQ_ERR=0, HOLD, full sequence completes to SEQ_DONE=1.
REQ-034 Async reset mid-GAP: assert RST between clock edges -> DOMAIN_RST=111 before the next edge; after release, the sequence restarts from domain 0.
REQ-035 Early/ignored inputs: hold all acks high from time 0 and pulse SW_RST_REQ during WAIT_ACK -> release order and timing are unchanged, with no restart.
